// File: rtl/shift_register_param.sv
// ============================================================================
// Module  : shift_register_param
// Brief   : WIDTH-bit universal shift/rotate/load register with counted burst engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_register_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic             DIR,
  input  logic             ARITH,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] CNT,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0]       MODE_SHIFT  = 2'b00;
  localparam logic [1:0]       MODE_ROTATE = 2'b01;
  localparam logic [1:0]       MODE_LOAD   = 2'b10;
  localparam logic [1:0]       MODE_HOLD   = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               sout_q, sout_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rot_q, rot_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;

  logic [WIDTH:0]     live_step;
  logic [WIDTH:0]     burst_step;

  // Returns {bit leaving the register, new register value} for one shift/rotate step.
  function automatic logic [WIDTH:0] step_op(
    input logic             rot,
    input logic             dir,
    input logic             arith,
    input logic             sin,
    input logic [WIDTH-1:0] q
  );
    logic fill;
    if (!dir) begin
      fill    = rot ? q[WIDTH-1] : sin;
      step_op = {q[WIDTH-1], q[WIDTH-2:0], fill};
    end else begin
      fill    = rot ? q[0] : (arith ? q[WIDTH-1] : sin);
      step_op = {q[0], fill, q[WIDTH-1:1]};
    end
  endfunction

  assign live_step  = step_op(MODO[0], DIR, ARITH, S_IN, q_q);
  assign burst_step = step_op(rot_q, dir_q, arith_q, S_IN, q_q);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    dir_d   = dir_q;
    arith_d = arith_q;

    unique case (state_q)
      ST_IDLE: begin
        if (START && !MODO[1]) begin
          // Accepted burst request: register output holds this cycle.
          if (CNT != CNT_ZERO) begin
            rot_d   = MODO[0];
            dir_d   = DIR;
            arith_d = ARITH;
            cnt_d   = CNT;
            state_d = ST_BURST;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          case (MODO)
            MODE_SHIFT,
            MODE_ROTATE: {sout_d, q_d} = live_step;
            MODE_LOAD: begin
              q_d    = D;
              sout_d = 1'b0;
            end
            MODE_HOLD: ;
            default: ;
          endcase
        end
      end
      ST_BURST: begin
        {sout_d, q_d} = burst_step;
        cnt_d         = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!ENB) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = sout_q;
  assign BUSY  = (state_q == ST_BURST);
  assign DONE  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_register_param.sv
// ============================================================================
// Module  : tb_shift_register_param
// Brief   : Scoreboard bench for shift_register_param (WIDTH=8, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_register_param;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          ENB;
  logic [1:0]    MODO;
  logic          DIR, ARITH, S_IN, START;
  logic [W-1:0]  D;
  logic [CW-1:0] CNT;
  logic [W-1:0]  Q;
  logic          S_OUT, BUSY, DONE;

  always #5 clk = ~clk;

  shift_register_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .ENB(ENB), .MODO(MODO), .DIR(DIR), .ARITH(ARITH), .S_IN(S_IN),
    .D(D), .START(START), .CNT(CNT), .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    logic [W+2:0] v;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] eq;
  logic         es;
  logic [W+2:0] obs;

  assign obs = {Q, S_OUT, BUSY, DONE};

  function automatic logic [W+2:0] pk(logic [W-1:0] q, logic s, logic b, logic d);
    return {q, s, b, d};
  endfunction

  function automatic exp_t mk(logic [W+2:0] v, string tag);
    exp_t x;
    x.v   = v;
    x.tag = tag;
    return x;
  endfunction

  // Reference model of one step: returns {s_out, q}.
  function automatic logic [W:0] model(logic [W-1:0] q, logic s, logic [1:0] m,
                                       logic dir, logic ar, logic sin, logic [W-1:0] d);
    logic [W-1:0] nq;
    logic         so;
    nq = q;
    so = s;
    if (m == 2'b10) begin
      nq = d;
      so = 1'b0;
    end else if (m != 2'b11) begin
      if (!dir) begin
        so = q[W-1];
        for (int i = W - 1; i > 0; i--) nq[i] = q[i-1];
        nq[0] = (m == 2'b01) ? q[W-1] : sin;
      end else begin
        so = q[0];
        for (int i = 0; i < W - 1; i++) nq[i] = q[i+1];
        nq[W-1] = (m == 2'b01) ? q[0] : (ar ? q[W-1] : sin);
      end
    end
    return {so, nq};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [W-1:0] val, string tag);
    MODO = 2'b10; D = val; START = 1'b0;
    sb.push_back(mk(pk(val, 1'b0, 1'b0, 1'b0), tag));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    eq = val; es = 1'b0;
  endtask

  task automatic test_reset();
    ENB = 1'b1;
    do_load(8'hFF, "load_ff");
    ENB = 1'b0; MODO = 2'b10; D = 8'hAA;
    sb.push_back(mk(pk(8'h00, 1'b0, 1'b0, 1'b0), "reset_over_load"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    ENB = 1'b1;
  endtask

  task automatic test_rotate();
    do_load(8'hA5, "load_a5");
    MODO = 2'b01; DIR = 1'b0; ARITH = 1'b1;
    sb.push_back(mk(pk(8'h4B, 1'b1, 1'b0, 1'b0), "rotl_1"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    sb.push_back(mk(pk(8'hA5, 1'b1, 1'b0, 1'b0), "rotl_8"));
    repeat (7) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    DIR = 1'b1;
    sb.push_back(mk(pk(8'hD2, 1'b1, 1'b0, 1'b0), "rotr_1"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
  endtask

  task automatic test_shift();
    do_load(8'h90, "load_90a");
    MODO = 2'b00; DIR = 1'b1; ARITH = 1'b1; S_IN = 1'b1;
    sb.push_back(mk(pk(8'hF2, 1'b0, 1'b0, 1'b0), "asr_3"));
    repeat (3) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    do_load(8'h90, "load_90b");
    MODO = 2'b00; DIR = 1'b1; ARITH = 1'b0; S_IN = 1'b0;
    sb.push_back(mk(pk(8'h12, 1'b0, 1'b0, 1'b0), "lsr_3"));
    repeat (3) tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    DIR = 1'b0; ARITH = 1'b1; S_IN = 1'b1;
    sb.push_back(mk(pk(8'h25, 1'b0, 1'b0, 1'b0), "lsl_arith_ignored"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
  endtask

  task automatic test_burst();
    logic [W-1:0] exp_q [5];
    logic         exp_b [5];
    logic         exp_d [5];
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_load(8'h01, "load_01");
    START = 1'b1; CNT = 4'd3; MODO = 2'b00; DIR = 1'b0; ARITH = 1'b0; S_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(pk(exp_q[i], 1'b0, exp_b[i], exp_d[i]), $sformatf("burst3_c%0d", i)));
      tick();
      if (i == 0) begin
        // Live controls must be ignored during the burst.
        MODO = 2'b11; DIR = 1'b1; CNT = 4'd7;
      end
      if (i == 2) START = 1'b0;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_abort();
    do_load(8'h81, "load_81");
    START = 1'b1; CNT = 4'd10; MODO = 2'b01; DIR = 1'b1;
    sb.push_back(mk(pk(eq, es, 1'b1, 1'b0), "abort_start"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    START = 1'b0; MODO = 2'b11;
    for (int i = 0; i < 4; i++) begin
      {es, eq} = model(eq, es, 2'b01, 1'b1, 1'b0, S_IN, D);
      sb.push_back(mk(pk(eq, es, 1'b1, 1'b0), $sformatf("abort_step%0d", i + 1)));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
    ENB = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk(pk(8'h00, 1'b0, 1'b0, 1'b0), $sformatf("abort_after%0d", i)));
      tick();
      ENB = 1'b1;
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
  endtask

  task automatic test_zero_cnt();
    do_load(8'h3C, "load_3c");
    START = 1'b1; CNT = 4'd0; MODO = 2'b00; DIR = 1'b0; S_IN = 1'b1;
    sb.push_back(mk(pk(8'h3C, 1'b0, 1'b0, 1'b1), "cnt0_done"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    START = 1'b0; MODO = 2'b11;
    sb.push_back(mk(pk(8'h3C, 1'b0, 1'b0, 1'b0), "cnt0_after"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
  endtask

  task automatic test_back_to_back();
    do_load(8'hB1, "load_b1");
    START = 1'b1; CNT = 4'd12; MODO = 2'b01; DIR = 1'b0;
    sb.push_back(mk(pk(eq, es, 1'b1, 1'b0), "b2b_start1"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    START = 1'b0; MODO = 2'b10; D = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      {es, eq} = model(eq, es, 2'b01, 1'b0, 1'b0, S_IN, D);
      sb.push_back(mk(pk(eq, es, i < 12, i == 12), $sformatf("b2b_rot%0d", i)));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
    // Rotating 12 steps wraps to a 4-step rotate of B1.
    sb.push_back(mk(pk(8'h1B, 1'b1, 1'b0, 1'b1), "b2b_wrap"));
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    START = 1'b1; CNT = 4'd9; MODO = 2'b00; DIR = 1'b0; S_IN = 1'b1;
    sb.push_back(mk(pk(eq, es, 1'b1, 1'b0), "b2b_start2"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    START = 1'b0; MODO = 2'b11;
    for (int i = 1; i <= 9; i++) begin
      {es, eq} = model(eq, es, 2'b00, 1'b0, 1'b0, 1'b1, D);
      sb.push_back(mk(pk(eq, es, i < 9, i == 9), $sformatf("b2b_shl%0d", i)));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
    sb.push_back(mk(pk(8'hFF, 1'b1, 1'b0, 1'b0), "b2b_flushed_hold"));
    tick();
    e = sb.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 60; i++) begin
      MODO  = 2'($urandom_range(0, 3));
      DIR   = 1'($urandom_range(0, 1));
      ARITH = 1'($urandom_range(0, 1));
      S_IN  = 1'($urandom_range(0, 1));
      D     = 8'($urandom_range(0, 255));
      CNT   = 4'($urandom_range(0, 15));
      START = MODO[1] ? 1'($urandom_range(0, 1)) : 1'b0;
      {es, eq} = model(eq, es, MODO, DIR, ARITH, S_IN, D);
      sb.push_back(mk(pk(eq, es, 1'b0, 1'b0), $sformatf("free_run%0d", i)));
      tick();
      e = sb.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.v); end
    end
  endtask

  initial begin
    ENB = 1'b0; MODO = 2'b11; DIR = 1'b0; ARITH = 1'b0; S_IN = 1'b0;
    START = 1'b0; D = '0; CNT = '0;
    eq = '0; es = 1'b0;
    repeat (2) tick();
    test_reset();
    test_rotate();
    test_shift();
    test_burst();
    test_abort();
    test_zero_cnt();
    test_back_to_back();
    test_free_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
